// File: rtl/glitc_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : glitc_clock_sequencer
// Purpose  : Sequences the GLITC sampling-clock MMCM reset, lock wait (with
//            timeout and retry), PLL settle time and datapath reset release.
//            It is driven by the control-register clock select and reset
//            pulse. Lock loss while running restarts the whole sequence.
// Ports    : user_clk_i      - single clock, all logic synchronous to it
//            user_rst_i      - asynchronous active-high reset
//            reset_req_i     - one-cycle restart request
//            clk_control_i   - requested clock configuration
//            mmcm_locked_i   - asynchronous MMCM lock (2-FF synchronized)
//            mmcm_rst_o      - MMCM reset
//            clk_sel_o       - applied clock configuration
//            datapath_rst_o  - datapath reset
//            ready_o         - clocks valid, datapath running
//            timeout_o       - sticky lock-failure flag
//            status_o        - {lock-loss cnt[7:0], 1'b0, retry[3:0], state[2:0]}
// Revision : 1.0 - initial release
// ============================================================================
module glitc_clock_sequencer #(
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int SETTLE_CYCLES   = 256,
  parameter int MAX_RETRIES     = 3
) (
  input  logic        user_clk_i,
  input  logic        user_rst_i,
  input  logic        reset_req_i,
  input  logic [2:0]  clk_control_i,
  input  logic        mmcm_locked_i,
  output logic        mmcm_rst_o,
  output logic [2:0]  clk_sel_o,
  output logic        datapath_rst_o,
  output logic        ready_o,
  output logic        timeout_o,
  output logic [15:0] status_o
);

  typedef enum logic [2:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Terminal counts: each state lasts exactly N cycles since cnt starts at 0.
  localparam logic [15:0] c_rst_last    = 16'(MMCM_RST_CYCLES - 1);
  localparam logic [15:0] c_lock_last   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] c_settle_last = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  c_max_retries = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic [2:0]  clk_sel_q, clk_sel_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  sync_q;
  logic        mmcm_rst_q, dp_rst_q, ready_q;

  logic        lock;
  logic        restart;
  logic        attempt_fail;
  logic [3:0]  retry_inc;

  // Two-flop synchronizer for the asynchronous lock input.
  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], mmcm_locked_i};
    end
  end

  assign lock      = sync_q[1];
  assign restart   = reset_req_i | (clk_control_i != clk_sel_q);
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    retry_d      = retry_q;
    loss_d       = loss_q;
    clk_sel_d    = clk_sel_q;
    timeout_d    = timeout_q;
    attempt_fail = 1'b0;

    if (restart) begin
      // Restart beats every state-specific transition, including lock loss.
      state_d   = ST_MMCM_RST;
      clk_sel_d = clk_control_i;
      retry_d   = 4'd0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_MMCM_RST: begin
          if (cnt_q == c_rst_last) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // Lock is checked first so a lock on the timeout cycle still wins.
          if (lock) begin
            state_d = ST_SETTLE;
          end else if (cnt_q == c_lock_last) begin
            attempt_fail = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!lock) begin
            attempt_fail = 1'b1;
          end else if (cnt_q == c_settle_last) begin
            state_d = ST_RUN;
            retry_d = 4'd0;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
          if (!lock) begin
            state_d = ST_MMCM_RST;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end
        end
        ST_FAULT: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_MMCM_RST;
        end
      endcase

      if (attempt_fail) begin
        retry_d = retry_inc;
        if (retry_inc == c_max_retries) begin
          state_d   = ST_FAULT;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_MMCM_RST;
        end
      end
    end

    // A restart in MMCM_RST keeps the state but must still restart the count.
    if (restart || (state_d != state_q)) cnt_d = 16'd0;
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      state_q    <= ST_MMCM_RST;
      cnt_q      <= 16'd0;
      retry_q    <= 4'd0;
      loss_q     <= 8'd0;
      clk_sel_q  <= 3'd0;
      timeout_q  <= 1'b0;
      mmcm_rst_q <= 1'b1;
      dp_rst_q   <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      clk_sel_q  <= clk_sel_d;
      timeout_q  <= timeout_d;
      // Outputs decoded from the next state so they change with the state.
      mmcm_rst_q <= (state_d == ST_MMCM_RST) || (state_d == ST_FAULT);
      dp_rst_q   <= (state_d != ST_RUN);
      ready_q    <= (state_d == ST_RUN);
    end
  end

  assign mmcm_rst_o     = mmcm_rst_q;
  assign clk_sel_o      = clk_sel_q;
  assign datapath_rst_o = dp_rst_q;
  assign ready_o        = ready_q;
  assign timeout_o      = timeout_q;
  assign status_o       = {loss_q, 1'b0, retry_q, state_q};

endmodule
`default_nettype wire

// File: doc/glitc_clock_sequencer.md
# glitc_clock_sequencer

Sequences the GLITC sampling-clock MMCM and datapath reset from the control-register outputs. Takes the 3-bit clock-control value and the one-cycle reset pulse, holds the MMCM in reset, waits for lock with timeout and retry, and lets the PLL settle before releasing the datapath reset. Lock loss while running restarts the sequence. Sits between the user-bus control registers and the clocking/datapath logic, all on `user_clk_i`.

## Interface
- `MMCM_RST_CYCLES`, default 16: cycles `mmcm_rst_o` is held per attempt (2..65535).
- `LOCK_TIMEOUT`, default 65535: cycles allowed in WAIT_LOCK per attempt (2..65535).
- `SETTLE_CYCLES`, default 256: cycles lock must persist before datapath release (2..65535).
- `MAX_RETRIES`, default 3: failed lock attempts before FAULT (1..15).
- `user_clk_i`  in  1  single clock; everything is synchronous to it.
- `user_rst_i`  in  1  reset, asynchronous, active-high.
- `reset_req_i`  in  1  one-cycle restart request (control-register reset bit).
- `clk_control_i`  in  3  requested clock configuration.
- `mmcm_locked_i`  in  1  MMCM lock, asynchronous; 2-FF synchronized internally.
- `mmcm_rst_o`  out  1  MMCM reset.
- `clk_sel_o`  out  3  applied clock configuration.
- `datapath_rst_o`  out  1  datapath reset.
- `ready_o`  out  1  clocks valid, datapath running.
- `timeout_o`  out  1  lock failure flag, sticky.
- `status_o`  out  16  [2:0] state, [6:3] retry count, [7] 0, [15:8] lock-loss count.

## Operation
- States: MMCM_RST=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4. One 16-bit counter `cnt`, cleared on every state change.
- Restart condition R = `reset_req_i` | (`clk_control_i` != `clk_sel_o`). R is evaluated in every state and has top priority. On R: state<=MMCM_RST, cnt<=0, `clk_sel_o`<=`clk_control_i`, retry<=0, `timeout_o`<=0.
- MMCM_RST: cnt++. At cnt==MMCM_RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: cnt++.
  - If synchronized lock==1, go to SETTLE.
  - Else at cnt==LOCK_TIMEOUT-1, retry++. If the new retry==MAX_RETRIES, go to FAULT and set `timeout_o`=1. Otherwise go to MMCM_RST.
- SETTLE: cnt++.
  - If lock==0, retry++ and apply the same MAX_RETRIES rule as WAIT_LOCK.
  - Else at cnt==SETTLE_CYCLES-1, go to RUN and set retry<=0.
- RUN: if lock==0, go to MMCM_RST and increment the lock-loss count (8-bit, saturates at 255).
- FAULT: stays until R.
- Output decode (registered, updated on the same edge as the state):
  - `mmcm_rst_o`=1 in MMCM_RST and FAULT.
  - `datapath_rst_o`=1 in every state except RUN.
  - `ready_o`=1 only in RUN.
- The lock-loss count is cleared only by `user_rst_i`.

## Timing
- Reset values: state MMCM_RST, cnt 0, retry 0, lock-loss 0, sync FFs 0, `clk_sel_o`=0, `mmcm_rst_o`=1, `datapath_rst_o`=1, `ready_o`=0, `timeout_o`=0, `status_o`=0x0000.
- After `user_rst_i` falls, `mmcm_rst_o` stays high for exactly MMCM_RST_CYCLES rising edges.
- Lock path latency: `mmcm_locked_i` rise to WAIT_LOCK exit is 2 sync cycles plus 1 state edge. `ready_o` then rises SETTLE_CYCLES edges after SETTLE entry.
- RUN lock-drop response: `mmcm_locked_i` fall to `ready_o`=0, `datapath_rst_o`=1 and `mmcm_rst_o`=1 is 3 edges.
- R reaction: outputs and `clk_sel_o` update on the edge sampling R. A `clk_control_i` change is applied 1 edge later.
- R during MMCM_RST restarts the full MMCM_RST_CYCLES count.
- R and lock loss in the same cycle in RUN: R wins; the lock-loss count is not incremented.
- WAIT_LOCK: lock arriving on the timeout cycle counts as locked (lock has priority over timeout).
- Asynchronous `user_rst_i` mid-sequence forces the reset values immediately, independent of the clock.

## Test plan
- Power-up, MMCM_RST_CYCLES=4, SETTLE_CYCLES=8. Lock asserted 10 cycles after reset release -> `mmcm_rst_o` high exactly 4 cycles. `ready_o` rises 11 edges after lock rise (2 sync + 1 + 8). `status_o`[2:0]=3.
- Lock never asserts, LOCK_TIMEOUT=20, MAX_RETRIES=3 -> three MMCM_RST pulses of 4 cycles each. Then FAULT: `mmcm_rst_o`=1, `timeout_o`=1, `status_o`[6:3]=3. A subsequent `reset_req_i` pulse clears `timeout_o` and restarts the sequence.
- In RUN, drop lock for 1 cycle -> `ready_o` falls 3 edges later, `status_o`[15:8]=1, full resequence runs. Repeat 300 times -> count saturates at 255.
- In RUN, change `clk_control_i` 0->5 -> `clk_sel_o`=5 and `mmcm_rst_o`=1 on the next edge, followed by a full sequence back to `ready_o`=1.
- `reset_req_i` on the same cycle as lock loss in RUN -> lock-loss count unchanged. Lock glitch low during SETTLE -> retry=1, returns to MMCM_RST.
- Assert `user_rst_i` asynchronously mid-SETTLE -> all outputs take reset values before the next clock edge.
